// File: rtl/maverickOne_pkg.sv
`default_nettype none
// ============================================================================
// Module   : maverickOne_pkg
// Brief    : Shared types and sizing for the maverickOne issue stage
//            register lock scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
package maverickOne_pkg;

  // Architectural register count; x0 is hardwired and never locked
  localparam int NUM_REGS     = 32;
  // Number of writeback ports returning results each cycle
  localparam int NUM_WB_PORTS = 2;

  // Scoreboard operating state: RUN tracks per-register locks, BLOCKED
  // presents every register as locked until the blocking instruction ends
  typedef enum logic [0:0] {
    RUN     = 1'b0,
    BLOCKED = 1'b1
  } reg_lock_state_e;

endpackage : maverickOne_pkg
`default_nettype wire

// File: rtl/rd_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module   : rd_onehot_dec
// Brief    : Register index to one-hot mask decoder with an enable. Bit 0
//            is always 0 so that x0 can never be locked or cleared.
// Revision : 1.0 - initial release
// ============================================================================
module rd_onehot_dec #(
  parameter int NR = 32,
  parameter int IW = $clog2(NR)
) (
  input  logic          i_en,
  input  logic [IW-1:0] i_idx,
  output logic [NR-1:0] o_onehot
);

  // Decode the index when enabled, then force the x0 position low
  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_idx] = 1'b1;
    end
    o_onehot[0] = 1'b0;
  end

endmodule : rd_onehot_dec
`default_nettype wire

// File: rtl/reg_lock_release.sv
`default_nettype none
// ============================================================================
// Module   : reg_lock_release
// Brief    : Release side of the register grant checker. Records locks for
//            granted instructions, clears them on writeback, tracks the
//            RUN/BLOCKED state for blocking instructions and the memory-busy
//            flag. Outputs are registered or decoded from registers only.
// Config   : REG_LOCK_RELEASE_ERR_EN - adds sticky protocol error output err_o
// Revision : 1.0 - initial release
// ============================================================================
module reg_lock_release
  import maverickOne_pkg::*;
#(
  parameter  int NR  = maverickOne_pkg::NUM_REGS,
  parameter  int NWB = maverickOne_pkg::NUM_WB_PORTS,
  localparam int IW  = $clog2(NR)
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              issue_valid_i,
  input  logic              issue_blocking_i,
  input  logic [IW-1:0]     issue_rd_i,
  input  logic              issue_mem_op_i,
  input  logic [NWB-1:0]    wb_valid_i,
  input  logic [NWB*IW-1:0] wb_rd_i,
  input  logic              blk_done_i,
  input  logic              mem_done_i,
  output logic [NR-1:0]     locks_o,
  output logic              mem_busy_o,
  output logic              idle_o
`ifdef REG_LOCK_RELEASE_ERR_EN
  ,
  output logic              err_o
`endif
);

  reg_lock_state_e r_state;
  reg_lock_state_e w_state_n;
  logic [NR-1:0]   r_locks;
  logic [NR-1:0]   w_locks_n;
  logic [NR-1:0]   w_set_mask;
  logic [NR-1:0]   w_wb_clr;
  logic [NR-1:0]   w_wb_mask [NWB];
  logic            r_mem_busy;
  logic            w_mem_busy_n;
  logic            w_issue_run;

  // Issues are only honoured in RUN; in BLOCKED the checker cannot grant
  assign w_issue_run = issue_valid_i & (r_state == RUN);

  rd_onehot_dec #(.NR(NR), .IW(IW)) u_issue_dec (
    .i_en     (w_issue_run & ~issue_blocking_i),
    .i_idx    (issue_rd_i),
    .o_onehot (w_set_mask)
  );

  generate
    for (genvar k = 0; k < NWB; k++) begin : g_wb_dec
      rd_onehot_dec #(.NR(NR), .IW(IW)) u_wb_dec (
        .i_en     (wb_valid_i[k]),
        .i_idx    (wb_rd_i[k*IW +: IW]),
        .o_onehot (w_wb_mask[k])
      );
    end
  endgenerate

  // Merge all writeback ports into one clear mask
  always_comb begin
    w_wb_clr = '0;
    for (int k = 0; k < NWB; k++) begin
      w_wb_clr = w_wb_clr | w_wb_mask[k];
    end
  end

  // State, shadow lock vector and memory-busy flag registers
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state    <= RUN;
      r_locks    <= '0;
      r_mem_busy <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_locks    <= w_locks_n;
      r_mem_busy <= w_mem_busy_n;
    end
  end

  // Next-state and output decode; set beats clear so a WAW re-lock survives
  // the older instruction's writeback
  always_comb begin
    w_state_n    = r_state;
    w_locks_n    = (r_locks & ~w_wb_clr) | w_set_mask;
    w_locks_n[0] = 1'b0;
    w_mem_busy_n = (w_issue_run & issue_mem_op_i) | (r_mem_busy & ~mem_done_i);
    locks_o      = r_locks;
    case (r_state)
      RUN: begin
        if (issue_valid_i & issue_blocking_i) begin
          w_state_n = BLOCKED;
        end
      end
      BLOCKED: begin
        locks_o = '1;
        if (blk_done_i) begin
          w_state_n = RUN;
        end
      end
      default: begin
        w_state_n = RUN;
      end
    endcase
  end

  assign mem_busy_o = r_mem_busy;
  assign idle_o     = (r_state == RUN) & ~(|r_locks) & ~r_mem_busy;

`ifdef REG_LOCK_RELEASE_ERR_EN
  logic r_err;
  logic w_err_evt;

  // Detect protocol violations that the normal path silently absorbs
  always_comb begin
    w_err_evt = 1'b0;
    if (issue_valid_i & (r_state == BLOCKED)) w_err_evt = 1'b1;
    if (blk_done_i & (r_state == RUN))       w_err_evt = 1'b1;
    if (mem_done_i & ~r_mem_busy)            w_err_evt = 1'b1;
    for (int k = 0; k < NWB; k++) begin
      // Writeback of a nonzero register that holds no lock
      if (|(w_wb_mask[k] & ~r_locks)) w_err_evt = 1'b1;
      // Two ports retiring the same nonzero register together
      for (int j = 0; j < k; j++) begin
        if (|(w_wb_mask[j] & w_wb_mask[k])) w_err_evt = 1'b1;
      end
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_err <= 1'b0;
    end else if (w_err_evt) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`endif

endmodule : reg_lock_release
`default_nettype wire

// File: tb/tb_reg_lock_release.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_lock_release
// Brief    : Directed self-checking bench for reg_lock_release with a
//            behavioural scoreboard model and hand-computed literal checks.
// Config   : REG_LOCK_RELEASE_ERR_EN - also checks err_o
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_lock_release;

  localparam int NR  = 32;
  localparam int NWB = 2;
  localparam int IW  = 5;

  logic              clk = 1'b0;
  logic              arst;
  logic              issue_valid;
  logic              issue_blocking;
  logic [IW-1:0]     issue_rd;
  logic              issue_mem_op;
  logic [NWB-1:0]    wb_valid;
  logic [NWB*IW-1:0] wb_rd;
  logic              blk_done;
  logic              mem_done;
  logic [NR-1:0]     locks;
  logic              mem_busy;
  logic              idle;
  logic              err;

  int vectors     = 0;
  int miscompares = 0;

  reg_lock_release #(.NR(NR), .NWB(NWB)) dut (
    .clk_i            (clk),
    .arst_i           (arst),
    .issue_valid_i    (issue_valid),
    .issue_blocking_i (issue_blocking),
    .issue_rd_i       (issue_rd),
    .issue_mem_op_i   (issue_mem_op),
    .wb_valid_i       (wb_valid),
    .wb_rd_i          (wb_rd),
    .blk_done_i       (blk_done),
    .mem_done_i       (mem_done),
    .locks_o          (locks),
    .mem_busy_o       (mem_busy),
    .idle_o           (idle)
`ifdef REG_LOCK_RELEASE_ERR_EN
    ,
    .err_o            (err)
`endif
  );

`ifndef REG_LOCK_RELEASE_ERR_EN
  assign err = 1'b0;
`endif

  always #5 clk = ~clk;

  // Behavioural model: a set of locked register numbers, a blocked flag,
  // a busy flag and a sticky error flag
  bit m_lock [NR];
  bit m_blk;
  bit m_busy;
  bit m_err;

  function automatic logic [NR-1:0] exp_locks();
    logic [NR-1:0] v;
    v = '0;
    if (m_blk) return '1;
    for (int i = 0; i < NR; i++) v[i] = m_lock[i];
    return v;
  endfunction

  function automatic bit exp_idle();
    return !m_blk && (exp_locks() == '0) && !m_busy;
  endfunction

  // Model update on each clock edge, reset asynchronously
  always @(posedge clk or posedge arst) begin
    bit nxt [NR];
    bit nblk, nbusy;
    int rd0, rd1, rd;
    if (arst) begin
      for (int i = 0; i < NR; i++) m_lock[i] = 1'b0;
      m_blk  = 1'b0;
      m_busy = 1'b0;
      m_err  = 1'b0;
    end else begin
      nxt   = m_lock;
      nblk  = m_blk;
      nbusy = m_busy && !mem_done;
      for (int k = 0; k < NWB; k++) begin
        if (wb_valid[k]) begin
          rd = int'(wb_rd[k*IW +: IW]);
          if (rd != 0) begin
            if (!m_lock[rd]) m_err = 1'b1;
            nxt[rd] = 1'b0;
          end
        end
      end
      rd0 = int'(wb_rd[IW-1:0]);
      rd1 = int'(wb_rd[2*IW-1:IW]);
      if (wb_valid == 2'b11 && rd0 == rd1 && rd0 != 0) m_err = 1'b1;
      if (mem_done && !m_busy) m_err = 1'b1;
      if (m_blk) begin
        if (issue_valid) m_err = 1'b1;
        if (blk_done) nblk = 1'b0;
      end else begin
        if (blk_done) m_err = 1'b1;
        if (issue_valid) begin
          if (issue_blocking) nblk = 1'b1;
          else if (issue_rd != 0) nxt[int'(issue_rd)] = 1'b1;
          if (issue_mem_op) nbusy = 1'b1;
        end
      end
      m_lock = nxt;
      m_blk  = nblk;
      m_busy = nbusy;
    end
  end

  task automatic check(input string name, input logic [NR-1:0] act, input logic [NR-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (!arst) begin
      check("model.locks", locks, exp_locks());
      check("model.mem_busy", {31'd0, mem_busy}, {31'd0, m_busy});
      check("model.idle", {31'd0, idle}, {31'd0, exp_idle()});
`ifdef REG_LOCK_RELEASE_ERR_EN
      check("model.err", {31'd0, err}, {31'd0, m_err});
`endif
    end
  end

  task automatic clear_inputs();
    issue_valid    = 1'b0;
    issue_blocking = 1'b0;
    issue_rd       = '0;
    issue_mem_op   = 1'b0;
    wb_valid       = '0;
    wb_rd          = '0;
    blk_done       = 1'b0;
    mem_done       = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic do_issue(input int rd, input bit blocking, input bit mem_op);
    issue_valid    = 1'b1;
    issue_rd       = IW'(rd);
    issue_blocking = blocking;
    issue_mem_op   = mem_op;
  endtask

  task automatic do_wb(input int port, input int rd);
    wb_valid[port]         = 1'b1;
    wb_rd[port*IW +: IW]   = IW'(rd);
  endtask

  initial begin
    arst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    check("reset.locks", locks, 32'h0);
    check("reset.mem_busy", {31'd0, mem_busy}, 32'd0);
    check("reset.idle", {31'd0, idle}, 32'd1);

    // Basic lock and release
    do_issue(5, 0, 0); tick();
    check("issue5.locks", locks, 32'h0000_0020);
    check("issue5.idle", {31'd0, idle}, 32'd0);
    do_wb(0, 5); tick();
    check("wb5.locks", locks, 32'h0);
    check("wb5.idle", {31'd0, idle}, 32'd1);

    // x0 never locks and its writeback is harmless
    do_issue(0, 0, 0); tick();
    check("issue0.locks", locks, 32'h0);
    do_wb(0, 0); tick();
    check("wb0.locks", locks, 32'h0);
`ifdef REG_LOCK_RELEASE_ERR_EN
    check("wb0.err", {31'd0, err}, 32'd0);
`endif

    // Re-lock and writeback of the same register together: set wins
    do_issue(7, 0, 0); tick();
    do_issue(7, 0, 0); do_wb(1, 7); tick();
    check("waw7.locks", locks, 32'h0000_0080);
    do_wb(0, 7); tick();
    check("wb7.locks", locks, 32'h0);

    // Blocking issue with clears arriving while blocked
    do_issue(3, 0, 0); tick();
    do_issue(9, 0, 0); tick();
    do_issue(0, 1, 0); tick();
    check("blocked.locks", locks, 32'hFFFF_FFFF);
    check("blocked.idle", {31'd0, idle}, 32'd0);
    do_wb(0, 3); tick();
    check("blocked_wb3.locks", locks, 32'hFFFF_FFFF);
    blk_done = 1'b1; tick();
    check("unblock.locks", locks, 32'h0000_0200);
    do_wb(1, 9); tick();
    check("wb9.locks", locks, 32'h0);

    // Memory busy set and clear
    do_issue(4, 0, 1); tick();
    check("mem.busy", {31'd0, mem_busy}, 32'd1);
    check("mem.locks", locks, 32'h0000_0010);
    mem_done = 1'b1; tick();
    check("memdone.busy", {31'd0, mem_busy}, 32'd0);
    do_wb(0, 4); tick();
    check("wb4.idle", {31'd0, idle}, 32'd1);
`ifdef REG_LOCK_RELEASE_ERR_EN
    check("pre_err.err", {31'd0, err}, 32'd0);
    mem_done = 1'b1; tick();
    check("spurious_done.err", {31'd0, err}, 32'd1);
`endif

    // Dual-port clear, same-cycle mem set/done, ignored events
    do_issue(10, 0, 0); tick();
    do_issue(11, 0, 0); tick();
    check("two_locks.locks", locks, 32'h0000_0C00);
    do_wb(0, 10); do_wb(1, 11); tick();
    check("dual_wb.locks", locks, 32'h0);
    do_issue(0, 0, 1); mem_done = 1'b1; tick();
    check("mem_set_wins.busy", {31'd0, mem_busy}, 32'd1);
    mem_done = 1'b1; tick();
    check("mem_clear.busy", {31'd0, mem_busy}, 32'd0);
    blk_done = 1'b1; tick();
    check("blkdone_run.idle", {31'd0, idle}, 32'd1);
    do_issue(0, 1, 0); tick();
    do_issue(6, 0, 1); tick();
    check("issue_blocked.busy", {31'd0, mem_busy}, 32'd0);
    blk_done = 1'b1; tick();
    check("issue_blocked.locks", locks, 32'h0);
    check("issue_blocked.idle", {31'd0, idle}, 32'd1);

    // Asynchronous reset while blocked with memory busy
    do_issue(2, 0, 1); tick();
    do_issue(0, 1, 0); tick();
    check("pre_rst.locks", locks, 32'hFFFF_FFFF);
    check("pre_rst.busy", {31'd0, mem_busy}, 32'd1);
    #2 arst = 1'b1;
    #1;
    check("async_rst.locks", locks, 32'h0);
    check("async_rst.busy", {31'd0, mem_busy}, 32'd0);
    check("async_rst.idle", {31'd0, idle}, 32'd1);
`ifdef REG_LOCK_RELEASE_ERR_EN
    check("async_rst.err", {31'd0, err}, 32'd0);
`endif
    @(posedge clk);
    #1 arst = 1'b0;
    tick();
    tick();
    check("post_rst.idle", {31'd0, idle}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_reg_lock_release
`default_nettype wire
